// File: rtl/serial_led_frame_receiver.sv
// Deserialises a colour-component serial stream and commits frames into LED or brightness registers.
// Latency: shift updates serial_data_out/bit_count on the sampling edge; latch results visible one cycle after the strobe.
// Backpressure: none; shift and latch are accepted every cycle and a held strobe acts once per clock.
module serial_led_frame_receiver #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             serial_data_in,
   input  logic             shift,
   input  logic             latch,
   input  logic             latch_sel,
   output logic [WIDTH-1:0] led_vals,
   output logic [WIDTH-1:0] brightness,
   output logic             serial_data_out,
   output logic [CNT_W-1:0] bit_count,
   output logic             frame_done,
   output logic             frame_error,
   input  logic             error_clr,
   output logic [15:0]      frame_count
);

   localparam int LOG_W = $clog2(WIDTH);

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] sr;
   logic [CNT_W-1:0] count_next;
   logic             saturated;
   logic             good_frame;

   // Next state, next bit count and frame-length verdict; a latch ends the frame,
   // and a shift in the same cycle becomes bit 1 of the following frame.
   always_comb begin
      state_next = state;
      count_next = bit_count;
      saturated  = &bit_count;
      good_frame = (state == RECV) && (bit_count[LOG_W-1:0] == '0) && !saturated;
      if (latch) begin
         state_next = shift ? RECV : IDLE;
         count_next = shift ? CNT_W'(1) : '0;
      end else if (shift) begin
         state_next = RECV;
         if (!saturated) begin
            count_next = bit_count + CNT_W'(1);
         end
      end
   end

   // State and bit counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         bit_count <= '0;
      end else begin
         state     <= state_next;
         bit_count <= count_next;
      end
   end

   // Shift register, MSB first; the bit leaving the top feeds the next chip in the chain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sr              <= '0;
         serial_data_out <= 1'b0;
      end else if (shift) begin
         sr              <= {sr[WIDTH-2:0], serial_data_in};
         serial_data_out <= sr[WIDTH-1];
      end
   end

   // Commit the pre-shift register on latch and keep frame statistics; an error set beats a clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         led_vals    <= '0;
         brightness  <= '0;
         frame_done  <= 1'b0;
         frame_error <= 1'b0;
         frame_count <= '0;
      end else begin
         frame_done <= latch;
         if (latch) begin
            if (latch_sel) begin
               brightness <= sr;
            end else begin
               led_vals <= sr;
            end
            if (good_frame) begin
               frame_count <= frame_count + 16'd1;
            end
         end
         if (latch && !good_frame) begin
            frame_error <= 1'b1;
         end else if (error_clr) begin
            frame_error <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_led_frame_receiver.sv
// Bench for serial_led_frame_receiver: directed scenarios plus randomized frames against a reference model.
// The model keeps the whole received bit history and derives register contents from it.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_serial_led_frame_receiver;

   logic        clk;
   logic        reset_n;
   logic        serial_data_in;
   logic        shift;
   logic        latch;
   logic        latch_sel;
   logic        error_clr;
   logic [15:0] led_vals;
   logic [15:0] brightness;
   logic        serial_data_out;
   logic [7:0]  bit_count;
   logic        frame_done;
   logic        frame_error;
   logic [15:0] frame_count;

   int errors = 0;
   int checks = 0;

   serial_led_frame_receiver #(.WIDTH(16), .CNT_W(8)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .serial_data_in  (serial_data_in),
      .shift           (shift),
      .latch           (latch),
      .latch_sel       (latch_sel),
      .led_vals        (led_vals),
      .brightness      (brightness),
      .serial_data_out (serial_data_out),
      .bit_count       (bit_count),
      .frame_done      (frame_done),
      .frame_error     (frame_error),
      .error_clr       (error_clr),
      .frame_count     (frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: full bit history since reset plus frame bookkeeping.
   logic        hist[$];
   int          m_cnt;
   logic [15:0] m_led, m_bri, m_fc;
   logic        m_sdo, m_done, m_err;

   typedef struct {
      logic sd;
      logic sh;
      logic la;
      logic sel;
      logic clr;
   } stim_t;

   function automatic logic [15:0] model_sr();
      logic [15:0] v;
      int n;
      v = '0;
      n = hist.size();
      for (int i = 0; i < 16; i++) begin
         if (n - 1 - i >= 0) v[i] = hist[n-1-i];
      end
      return v;
   endfunction

   task automatic model_reset();
      hist.delete();
      m_cnt = 0; m_led = '0; m_bri = '0; m_fc = '0;
      m_sdo = 1'b0; m_done = 1'b0; m_err = 1'b0;
   endtask

   task automatic model_step(input logic sd, input logic sh, input logic la, input logic sel, input logic clr);
      logic [15:0] pre;
      logic good;
      int n;
      pre  = model_sr();
      n    = hist.size();
      good = (m_cnt > 0) && (m_cnt % 16 == 0) && (m_cnt < 255);
      m_done = la;
      if (la) begin
         if (sel) m_bri = pre;
         else     m_led = pre;
         if (good) m_fc = m_fc + 16'd1;
      end
      if (la && !good) m_err = 1'b1;
      else if (clr)    m_err = 1'b0;
      if (sh) begin
         m_sdo = (n >= 16) ? hist[n-16] : 1'b0;
         hist.push_back(sd);
      end
      if (la)                      m_cnt = sh ? 1 : 0;
      else if (sh && m_cnt < 255)  m_cnt = m_cnt + 1;
   endtask

   // One clock of stimulus; returns at the following falling edge.
   task automatic cycle(input logic sd, input logic sh, input logic la, input logic sel, input logic clr);
      serial_data_in = sd; shift = sh; latch = la; latch_sel = sel; error_clr = clr;
      @(posedge clk);
      model_step(sd, sh, la, sel, clr);
      @(negedge clk);
      shift = 1'b0; latch = 1'b0; error_clr = 1'b0;
   endtask

   task automatic shift_word(input logic [15:0] w);
      for (int i = 15; i >= 0; i--) cycle(w[i], 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; serial_data_in = 1'b0; shift = 1'b0; latch = 1'b0; latch_sel = 1'b0; error_clr = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({led_vals, brightness, serial_data_out, bit_count, frame_done, frame_error, frame_count} !== '0) begin
         errors++;
         $display("FAIL reset_state got led=%h bri=%h sdo=%b cnt=%0d done=%b err=%b fc=%0d, want all 0",
                  led_vals, brightness, serial_data_out, bit_count, frame_done, frame_error, frame_count);
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_led_frame();
      shift_word(16'hA5C3);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (led_vals !== 16'hA5C3) begin errors++; $display("FAIL led_frame_val got %h want a5c3", led_vals); end
      checks++;
      if (frame_done !== 1'b1) begin errors++; $display("FAIL led_frame_done got %b want 1", frame_done); end
      checks++;
      if (frame_count !== 16'd1) begin errors++; $display("FAIL led_frame_count got %0d want 1", frame_count); end
      checks++;
      if (frame_error !== 1'b0) begin errors++; $display("FAIL led_frame_err got %b want 0", frame_error); end
      checks++;
      if (bit_count !== 8'd0) begin errors++; $display("FAIL led_frame_bitcnt got %0d want 0", bit_count); end
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (frame_done !== 1'b0) begin errors++; $display("FAIL led_frame_done_pulse got %b want 0", frame_done); end
   endtask

   task automatic test_brightness();
      shift_word(16'h00FF);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (brightness !== 16'h00FF) begin errors++; $display("FAIL bri_val got %h want 00ff", brightness); end
      checks++;
      if (led_vals !== 16'hA5C3) begin errors++; $display("FAIL bri_led_kept got %h want a5c3", led_vals); end
      checks++;
      if (frame_count !== 16'd2) begin errors++; $display("FAIL bri_count got %0d want 2", frame_count); end
   endtask

   task automatic test_daisy_chain();
      logic [31:0] w;
      logic [15:0] cap;
      w = {16'h1234, 16'hBEEF};
      cap = '0;
      for (int i = 31; i >= 0; i--) begin
         cycle(w[i], 1'b1, 1'b0, 1'b0, 1'b0);
         if (i <= 15) cap = {cap[14:0], serial_data_out};
      end
      checks++;
      if (bit_count !== 8'd32) begin errors++; $display("FAIL daisy_bitcnt got %0d want 32", bit_count); end
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (led_vals !== 16'hBEEF) begin errors++; $display("FAIL daisy_led got %h want beef", led_vals); end
      checks++;
      if (cap !== 16'h1234) begin errors++; $display("FAIL daisy_sdo got %h want 1234", cap); end
      checks++;
      if (frame_error !== 1'b0) begin errors++; $display("FAIL daisy_err got %b want 0", frame_error); end
      checks++;
      if (frame_count !== 16'd3) begin errors++; $display("FAIL daisy_count got %0d want 3", frame_count); end
   endtask

   task automatic test_bad_length();
      logic [15:0] w;
      w = 16'($urandom);
      for (int i = 0; i < 15; i++) cycle(w[i], 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (frame_error !== 1'b1) begin errors++; $display("FAIL short_err got %b want 1", frame_error); end
      checks++;
      if (frame_count !== 16'd3) begin errors++; $display("FAIL short_count got %0d want 3", frame_count); end
      shift_word(16'($urandom));
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (frame_error !== 1'b1) begin errors++; $display("FAIL sticky_err got %b want 1", frame_error); end
      checks++;
      if (frame_count !== 16'd4) begin errors++; $display("FAIL sticky_count got %0d want 4", frame_count); end
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (frame_error !== 1'b0) begin errors++; $display("FAIL err_clr got %b want 0", frame_error); end
   endtask

   task automatic test_shift_latch();
      shift_word(16'hFFFF);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (led_vals !== 16'hFFFF) begin errors++; $display("FAIL sl_led got %h want ffff", led_vals); end
      checks++;
      if (bit_count !== 8'd1) begin errors++; $display("FAIL sl_bitcnt got %0d want 1", bit_count); end
      checks++;
      if (frame_count !== 16'd5) begin errors++; $display("FAIL sl_count got %0d want 5", frame_count); end
   endtask

   task automatic test_reset_midframe();
      for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if ({led_vals, brightness, serial_data_out, bit_count, frame_done, frame_error, frame_count} !== '0) begin
         errors++;
         $display("FAIL async_reset got led=%h bri=%h sdo=%b cnt=%0d done=%b err=%b fc=%0d, want all 0",
                  led_vals, brightness, serial_data_out, bit_count, frame_done, frame_error, frame_count);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      shift_word(16'h8001);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (led_vals !== 16'h8001) begin errors++; $display("FAIL post_reset_led got %h want 8001", led_vals); end
      checks++;
      if (frame_error !== 1'b0) begin errors++; $display("FAIL post_reset_err got %b want 0", frame_error); end
      checks++;
      if (frame_count !== 16'd1) begin errors++; $display("FAIL post_reset_count got %0d want 1", frame_count); end
   endtask

   // Random frames of legal, short, long, empty and saturating lengths, with gaps,
   // simultaneous shift+latch and occasional error clears, checked cycle by cycle.
   task automatic test_random();
      stim_t q[$];
      stim_t s;
      int len;
      for (int f = 0; f < 60; f++) begin
         case ($urandom_range(0, 7))
            0: len = 16;
            1: len = 32;
            2: len = 15;
            3: len = 17;
            4: len = 0;
            5: len = $urandom_range(1, 40);
            6: len = 240;
            default: len = (f % 2 == 1) ? 256 : 300;
         endcase
         for (int b = 0; b < len; ) begin
            s.sd  = 1'($urandom_range(0, 1));
            s.la  = 1'b0;
            s.sel = 1'($urandom_range(0, 1));
            s.clr = ($urandom_range(0, 9) == 0);
            s.sh  = ($urandom_range(0, 4) != 0);
            if (s.sh) b++;
            q.push_back(s);
         end
         s.sd  = 1'($urandom_range(0, 1));
         s.sh  = ($urandom_range(0, 3) == 0);
         s.la  = 1'b1;
         s.sel = 1'($urandom_range(0, 1));
         s.clr = ($urandom_range(0, 3) == 0);
         q.push_back(s);
      end
      foreach (q[k]) begin
         cycle(q[k].sd, q[k].sh, q[k].la, q[k].sel, q[k].clr);
         checks++;
         if (led_vals !== m_led) begin errors++; $display("FAIL rand_led step %0d got %h want %h", k, led_vals, m_led); end
         checks++;
         if (brightness !== m_bri) begin errors++; $display("FAIL rand_bri step %0d got %h want %h", k, brightness, m_bri); end
         checks++;
         if (serial_data_out !== m_sdo) begin errors++; $display("FAIL rand_sdo step %0d got %b want %b", k, serial_data_out, m_sdo); end
         checks++;
         if (bit_count !== 8'(m_cnt)) begin errors++; $display("FAIL rand_bitcnt step %0d got %0d want %0d", k, bit_count, m_cnt); end
         checks++;
         if (frame_done !== m_done) begin errors++; $display("FAIL rand_done step %0d got %b want %b", k, frame_done, m_done); end
         checks++;
         if (frame_error !== m_err) begin errors++; $display("FAIL rand_err step %0d got %b want %b", k, frame_error, m_err); end
         checks++;
         if (frame_count !== m_fc) begin errors++; $display("FAIL rand_count step %0d got %0d want %0d", k, frame_count, m_fc); end
      end
   endtask

   initial begin
      test_reset();
      test_led_frame();
      test_brightness();
      test_daisy_chain();
      test_bad_length();
      test_shift_latch();
      test_reset_midframe();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
